// File: rtl/dm_write_dumper.sv
// Shadow copy of the data-memory write port with per-word dirty bits; a rising edge on
// dump streams every dirty word, in ascending index order, over a valid/ready port.
module dm_write_dumper #(
    parameter int unsigned N     = 64,
    parameter int unsigned DEPTH = 64,
    localparam int unsigned IW   = $clog2(DEPTH)
) (
    input  logic          CLOCK_50,
    input  logic          reset,
    input  logic          DM_writeEnable,
    input  logic [N-1:0]  DM_addr,
    input  logic [N-1:0]  DM_writeData,
    input  logic          dump,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [IW-1:0] out_index,
    output logic [N-1:0]  out_data,
    output logic          busy,
    output logic          done,
    output logic [15:0]   wr_count,
    output logic          err_misaligned,
    output logic          err_range,
    output logic          err_wr_busy
);

    typedef enum logic [1:0] {StIdle, StScan, StEmit, StDone} state_e;

    localparam logic [IW-1:0]  LastIdx = IW'(DEPTH - 1);
    localparam logic [N-4:0]   DepthW  = (N - 3)'(DEPTH);

    state_e           state_q, state_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic             dump_q;
    logic [DEPTH-1:0] dirty_q;
    logic [N-1:0]     mem [DEPTH];
    logic [15:0]      wr_count_q;
    logic             err_misaligned_q, err_range_q, err_wr_busy_q;

    logic          is_idle;
    logic          aligned;
    logic          in_range;
    logic          accept;
    logic          dump_rise;
    logic [IW-1:0] wr_idx;

    assign is_idle   = (state_q == StIdle);
    assign aligned   = (DM_addr[2:0] == 3'b000);
    assign in_range  = (DM_addr[N-1:3] < DepthW);
    assign wr_idx    = DM_addr[IW+2:3];
    assign accept    = DM_writeEnable & is_idle & aligned & in_range;
    assign dump_rise = dump & ~dump_q;

    // Contents are deliberately not reset; only the dirty bits say what is valid.
    always_ff @(posedge CLOCK_50) begin
        if (accept) begin
            mem[wr_idx] <= DM_writeData;
        end
    end

    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            state_q          <= StIdle;
            idx_q            <= '0;
            dump_q           <= 1'b0;
            dirty_q          <= '0;
            wr_count_q       <= '0;
            err_misaligned_q <= 1'b0;
            err_range_q      <= 1'b0;
            err_wr_busy_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            dump_q  <= dump;
            if (accept) begin
                dirty_q[wr_idx] <= 1'b1;
                if (wr_count_q != 16'hFFFF) begin
                    wr_count_q <= wr_count_q + 16'd1;
                end
            end
            if (DM_writeEnable && is_idle && !aligned) begin
                err_misaligned_q <= 1'b1;
            end
            if (DM_writeEnable && is_idle && !in_range) begin
                err_range_q <= 1'b1;
            end
            if (DM_writeEnable && !is_idle) begin
                err_wr_busy_q <= 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        unique case (state_q)
            StIdle: begin
                if (dump_rise) begin
                    state_d = StScan;
                    idx_d   = '0;
                end
            end
            StScan: begin
                if (dirty_q[idx_q]) begin
                    state_d = StEmit;
                end else if (idx_q == LastIdx) begin
                    state_d = StDone;
                end else begin
                    idx_d = idx_q + IW'(1);
                end
            end
            StEmit: begin
                if (out_ready) begin
                    if (idx_q == LastIdx) begin
                        state_d = StDone;
                    end else begin
                        state_d = StScan;
                        idx_d   = idx_q + IW'(1);
                    end
                end
            end
            StDone: begin
                if (!dump) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs decode straight from state so a reset drops them without waiting for a clock.
    always_comb begin
        out_valid = (state_q == StEmit);
        out_index = out_valid ? idx_q : '0;
        out_data  = out_valid ? mem[idx_q] : '0;
        busy      = (state_q == StScan) || (state_q == StEmit);
        done      = (state_q == StDone);
    end

    assign wr_count       = wr_count_q;
    assign err_misaligned = err_misaligned_q;
    assign err_range      = err_range_q;
    assign err_wr_busy    = err_wr_busy_q;

endmodule

// File: tb/tb_dm_write_dumper.sv
// Directed bench for dm_write_dumper: stores, dumps, stalls, busy stores and mid-dump reset.
module tb_dm_write_dumper;

    logic        CLOCK_50 = 1'b0;
    logic        reset;
    logic        DM_writeEnable;
    logic [63:0] DM_addr;
    logic [63:0] DM_writeData;
    logic        dump;
    logic        out_valid;
    logic        out_ready;
    logic [5:0]  out_index;
    logic [63:0] out_data;
    logic        busy;
    logic        done;
    logic [15:0] wr_count;
    logic        err_misaligned;
    logic        err_range;
    logic        err_wr_busy;

    int unsigned passes = 0;
    int unsigned total  = 0;

    logic [63:0] em_idx[$];
    logic [63:0] em_dat[$];

    int cycles;
    int first_valid;
    int n;

    dm_write_dumper #(.N(64), .DEPTH(64)) dut (
        .CLOCK_50       (CLOCK_50),
        .reset          (reset),
        .DM_writeEnable (DM_writeEnable),
        .DM_addr        (DM_addr),
        .DM_writeData   (DM_writeData),
        .dump           (dump),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_index      (out_index),
        .out_data       (out_data),
        .busy           (busy),
        .done           (done),
        .wr_count       (wr_count),
        .err_misaligned (err_misaligned),
        .err_range      (err_range),
        .err_wr_busy    (err_wr_busy)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    task automatic tick();
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic store(input logic [63:0] addr, input logic [63:0] data);
        DM_writeEnable = 1'b1;
        DM_addr        = addr;
        DM_writeData   = data;
        tick();
        DM_writeEnable = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();
    endtask

    // Holds dump high, logs every handshake, stops at done or when the budget runs out.
    task automatic run_dump(input int budget);
        dump        = 1'b1;
        cycles      = 0;
        first_valid = -1;
        while (done !== 1'b1 && cycles < budget) begin
            if (out_valid === 1'b1 && first_valid < 0) first_valid = cycles;
            if (out_valid === 1'b1 && out_ready === 1'b1) begin
                em_idx.push_back(64'(out_index));
                em_dat.push_back(out_data);
            end
            tick();
            cycles++;
        end
        check("dump_reaches_done", 64'(done), 64'd1);
    endtask

    task automatic end_dump();
        dump = 1'b0;
        tick();
        check("back_idle_done", 64'(done), 64'd0);
        check("back_idle_busy", 64'(busy), 64'd0);
    endtask

    initial begin
        reset          = 1'b0;
        DM_writeEnable = 1'b0;
        DM_addr        = '0;
        DM_writeData   = '0;
        dump           = 1'b0;
        out_ready      = 1'b1;
        tick();
        tick();
        reset = 1'b1;
        tick();

        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_wr_count", 64'(wr_count), 64'd0);
        check("rst_err_flags", 64'({err_misaligned, err_range, err_wr_busy}), 64'd0);
        check("rst_out_index", 64'(out_index), 64'd0);
        check("rst_out_data", out_data, 64'd0);

        // Three scattered stores including the last word.
        store(64'h0, 64'hAA);
        store(64'h18, 64'hBB);
        store(64'h1F8, 64'hCC);
        check("t1_wr_count", 64'(wr_count), 64'd3);
        em_idx.delete();
        em_dat.delete();
        run_dump(300);
        check("t1_first_latency", 64'(first_valid), 64'd2);
        check("t1_num_emitted", 64'(em_idx.size()), 64'd3);
        if (em_idx.size() == 3) begin
            check("t1_idx0", em_idx[0], 64'd0);
            check("t1_dat0", em_dat[0], 64'hAA);
            check("t1_idx1", em_idx[1], 64'd3);
            check("t1_dat1", em_dat[1], 64'hBB);
            check("t1_idx2", em_idx[2], 64'd63);
            check("t1_dat2", em_dat[2], 64'hCC);
        end
        check("t1_done_holds", 64'(done), 64'd1);
        end_dump();

        // Overwrite, with the second store coinciding with the dump edge.
        do_reset();
        store(64'h8, 64'h11);
        DM_writeEnable = 1'b1;
        DM_addr        = 64'h8;
        DM_writeData   = 64'h22;
        dump           = 1'b1;
        tick();
        DM_writeEnable = 1'b0;
        em_idx.delete();
        em_dat.delete();
        run_dump(300);
        check("t2_wr_count", 64'(wr_count), 64'd2);
        check("t2_num_emitted", 64'(em_idx.size()), 64'd1);
        if (em_idx.size() == 1) begin
            check("t2_idx", em_idx[0], 64'd1);
            check("t2_dat", em_dat[0], 64'h22);
        end
        end_dump();

        // Misaligned then out-of-range; nothing dirty.
        do_reset();
        store(64'h4, 64'h1234);
        check("t3_misaligned", 64'(err_misaligned), 64'd1);
        check("t3_range_clear", 64'(err_range), 64'd0);
        store(64'h200, 64'h5678);
        check("t3_range", 64'(err_range), 64'd1);
        check("t3_misaligned_sticky", 64'(err_misaligned), 64'd1);
        check("t3_wr_count", 64'(wr_count), 64'd0);
        em_idx.delete();
        em_dat.delete();
        run_dump(300);
        check("t3_scan_cycles", 64'(cycles), 64'd65);
        check("t3_never_valid", 64'(first_valid), 64'hFFFF_FFFF_FFFF_FFFF);
        check("t3_num_emitted", 64'(em_idx.size()), 64'd0);
        end_dump();

        // Backpressure on word 5.
        do_reset();
        store(64'h28, 64'h5555_0000_1234_5678);
        out_ready = 1'b0;
        dump      = 1'b1;
        n         = 0;
        while (out_valid !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check("t4_first_latency", 64'(n), 64'd7);
        for (int k = 0; k < 10; k++) begin
            check("t4_stall_valid", 64'(out_valid), 64'd1);
            check("t4_stall_index", 64'(out_index), 64'd5);
            check("t4_stall_data", out_data, 64'h5555_0000_1234_5678);
            tick();
        end
        out_ready = 1'b1;
        tick();
        check("t4_valid_drops", 64'(out_valid), 64'd0);
        em_idx.delete();
        em_dat.delete();
        run_dump(300);
        check("t4_no_more_words", 64'(em_idx.size()), 64'd0);
        end_dump();

        // Store during SCAN is dropped; second dump repeats the set.
        do_reset();
        store(64'h0, 64'hAA);
        store(64'h10, 64'h77);
        dump = 1'b1;
        tick();
        store(64'h20, 64'h99);
        check("t5_err_wr_busy", 64'(err_wr_busy), 64'd1);
        em_idx.delete();
        em_dat.delete();
        run_dump(300);
        check("t5_wr_count", 64'(wr_count), 64'd2);
        check("t5_num_emitted", 64'(em_idx.size()), 64'd2);
        end_dump();
        em_idx.delete();
        em_dat.delete();
        run_dump(300);
        check("t5_redump_num", 64'(em_idx.size()), 64'd2);
        if (em_idx.size() == 2) begin
            check("t5_redump_idx0", em_idx[0], 64'd0);
            check("t5_redump_dat0", em_dat[0], 64'hAA);
            check("t5_redump_idx1", em_idx[1], 64'd2);
            check("t5_redump_dat1", em_dat[1], 64'h77);
        end
        check("t5_err_busy_sticky", 64'(err_wr_busy), 64'd1);
        end_dump();

        // Reset while emitting.
        do_reset();
        store(64'h30, 64'hDEAD);
        out_ready = 1'b0;
        dump      = 1'b1;
        n         = 0;
        while (out_valid !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check("t6_in_emit", 64'(out_valid), 64'd1);
        #5;
        reset = 1'b0;
        #1;
        check("t6_async_valid", 64'(out_valid), 64'd0);
        check("t6_async_busy", 64'(busy), 64'd0);
        check("t6_async_done", 64'(done), 64'd0);
        dump      = 1'b0;
        out_ready = 1'b1;
        tick();
        reset = 1'b1;
        tick();
        check("t6_wr_count", 64'(wr_count), 64'd0);
        em_idx.delete();
        em_dat.delete();
        run_dump(300);
        check("t6_scan_cycles", 64'(cycles), 64'd65);
        check("t6_num_emitted", 64'(em_idx.size()), 64'd0);
        end_dump();

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
